ifu: RTL and testbench

- Instruction fetch unit directly upstream of the control unit.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel with a single outstanding transaction.
- Buffers returned instructions with their PCs in a 2-entry queue feeding decode, which consumes `inst` through a valid/ready handshake.
- Applies redirects (taken branch, JAL, JALR, trap) from execute, discarding stale in-flight responses.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_ibuf.sv | 84 ++++++++
 rtl/ifu.sv | 126 ++++++++++++
 tb/tb_ifu.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t      fetch FSM states (RUN, WAIT, DRAIN, HALT)
//   DEF_XLEN         default PC / address width
//   DEFAULT_RESET_PC default fetch PC loaded on reset
//   INST_NOP         canonical NOP (addi x0, x0, 0)
//   ILEN             instruction word width
package ifu_pkg;

   localparam int          DEF_XLEN         = 64;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
   localparam int          ILEN             = 32;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;

   // RUN   : no request outstanding, may issue one
   // WAIT  : one request outstanding, its response will be kept
   // DRAIN : one request outstanding, its response is stale and dropped
   // HALT  : misaligned redirect seen, fetch stopped
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } ifu_state_t;

endpackage

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: 2-entry FIFO of {pc, instruction} between fetch and decode.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push_i, push_pc_i,
//   push_inst_i            write one entry at the tail
//   pop_i                  remove the head (ignored when empty)
//   flush_i                discard all entries; wins over push and pop
//   count_o                number of valid entries (0..2)
//   head_valid_o           count_o != 0
//   head_pc_o, head_inst_o head entry; NOP / zero when empty
module ifu_ibuf
   import ifu_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic [XLEN-1:0] push_pc_i,
   input  logic [ILEN-1:0] push_inst_i,
   input  logic            pop_i,
   input  logic            flush_i,
   output logic [1:0]      count_o,
   output logic            head_valid_o,
   output logic [XLEN-1:0] head_pc_o,
   output logic [ILEN-1:0] head_inst_o
);

   logic [XLEN-1:0] pc_q   [2];
   logic [ILEN-1:0] inst_q [2];
   logic            rd_ptr_q, rd_ptr_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic [1:0]      count_q, count_d;
   logic            do_push, do_pop;

   assign do_push = push_i && !flush_i && (count_q != 2'd2);
   assign do_pop  = pop_i  && !flush_i && (count_q != 2'd0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) wr_ptr_d = ~wr_ptr_q;
         if (do_pop)  rd_ptr_d = ~rd_ptr_q;
         // simultaneous push and pop leaves the count unchanged
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; validity is carried by count_q.
   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_q[wr_ptr_q]   <= push_pc_i;
         inst_q[wr_ptr_q] <= push_inst_i;
      end
   end

   assign count_o      = count_q;
   assign head_valid_o = (count_q != 2'd0);
   assign head_pc_o    = head_valid_o ? pc_q[rd_ptr_q]   : '0;
   assign head_inst_o  = head_valid_o ? inst_q[rd_ptr_q] : INST_NOP;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit.
// Holds the fetch PC, issues one word request at a time to instruction
// memory, buffers returned words with their PCs, and applies redirects.
//
// Handshakes: a transfer on a channel happens in a cycle where both its
// valid and ready are high at the rising edge. imem_req_valid/addr stay
// stable until accepted unless a redirect withdraws them. inst/inst_pc
// stay stable while inst_valid && !inst_ready. The memory response has no
// ready: it is taken in the cycle imem_resp_valid is high.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready/addr         request channel (word aligned)
//   imem_resp_valid/data              response (>=1 cycle after accept)
//   redirect_valid/redirect_pc        pipeline redirect from execute
//   inst_valid/inst/inst_pc/inst_ready head of the fetch buffer to decode
//   fetch_fault                       sticky misaligned-redirect flag
module ifu
   import ifu_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready,
   output logic            fetch_fault
);

   ifu_state_t      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            fault_q, fault_d;

   logic            buf_push, buf_flush;
   logic [1:0]      buf_count;
   logic            req_fire;
   logic            redirect_misaligned;

   assign imem_req_valid      = (state_q == RUN) && (buf_count != 2'd2);
   assign imem_req_addr       = {fetch_pc_q[XLEN-1:2], 2'b00};
   assign req_fire            = imem_req_valid && imem_req_ready;
   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fault_d    = fault_q;
      buf_push   = 1'b0;
      buf_flush  = 1'b0;

      if (redirect_valid) begin
         buf_flush  = 1'b1;
         fetch_pc_d = redirect_pc;
         fault_d    = redirect_misaligned;
         // DRAIN whenever a request will still be outstanding after this edge
         case (state_q)
            RUN:     state_d = req_fire        ? DRAIN : RUN;
            WAIT:    state_d = imem_resp_valid ? RUN   : DRAIN;
            DRAIN:   state_d = imem_resp_valid ? RUN   : DRAIN;
            HALT:    state_d = RUN;
            default: state_d = RUN;
         endcase
         // a faulting redirect lands in HALT once nothing is in flight
         if (redirect_misaligned && (state_d == RUN)) state_d = HALT;
      end else begin
         case (state_q)
            RUN: begin
               if (req_fire) state_d = WAIT;
            end
            WAIT: begin
               if (imem_resp_valid) begin
                  buf_push   = 1'b1;
                  fetch_pc_d = fetch_pc_q + XLEN'(4);
                  state_d    = RUN;
               end
            end
            DRAIN: begin
               if (imem_resp_valid) state_d = fault_q ? HALT : RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fault_q    <= fault_d;
      end
   end

   assign fetch_fault = fault_q;

   ifu_ibuf #(
      .XLEN (XLEN)
   ) u_ibuf (
      .clk          (clk),
      .rst          (rst),
      .push_i       (buf_push),
      .push_pc_i    (fetch_pc_q),
      .push_inst_i  (imem_resp_data),
      .pop_i        (inst_ready),
      .flush_i      (buf_flush),
      .count_o      (buf_count),
      .head_valid_o (inst_valid),
      .head_pc_o    (inst_pc),
      .head_inst_o  (inst)
   );

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  localparam int XLEN = 64;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            fetch_fault;

  logic        auto_mem;
  logic        auto_resp_valid;
  logic [31:0] auto_resp_data;
  logic        man_resp_valid;
  logic [31:0] man_resp_data;

  assign imem_resp_valid = auto_mem ? auto_resp_valid : man_resp_valid;
  assign imem_resp_data  = auto_mem ? auto_resp_data  : man_resp_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [XLEN-1:0]    req_log[$];
  logic [XLEN+31:0]   inst_log[$];

  ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .fetch_fault     (fetch_fault)
  );

  // clock
  always #5 clk = ~clk;

  // memory image: addi x0,x0,imm with imm = word index bits
  function automatic logic [31:0] img(input logic [63:0] a);
    return {a[13:2], 20'h00013};
  endfunction

  // auto memory: 1-cycle response to every accepted request
  initial begin : responder
    logic [63:0] a;
    auto_resp_valid = 1'b0;
    auto_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (auto_mem && imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        @(posedge clk); #1;
        auto_resp_valid = 1'b1;
        auto_resp_data  = img(a);
        @(posedge clk); #1;
        auto_resp_valid = 1'b0;
      end
    end
  end

  // monitors: accepted requests and consumed instructions
  always @(negedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (!rst && inst_valid && inst_ready) inst_log.push_back({inst_pc, inst});
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    auto_mem       = 1'b0;
    man_resp_valid = 1'b0;
    man_resp_data  = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    tests_run++;
    if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid); end
    tests_run++;
    if (imem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RST_PC); end
    tests_run++;
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int rb, ib;
    logic [XLEN+31:0] e;
    do_reset();
    rb = req_log.size();
    ib = inst_log.size();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    auto_mem       = 1'b1;
    repeat (8) cycle();
    tests_run++;
    if ((req_log.size() - rb >= 3) !== 1'b1 || (inst_log.size() - ib >= 3) !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_count reqs=%0d insts=%0d exp>=3", req_log.size() - rb, inst_log.size() - ib);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (req_log[rb+i] !== RST_PC + 64'(4*i)) begin
          tests_failed++;
          $display("FAIL stream_req%0d got=%h exp=%h", i, req_log[rb+i], RST_PC + 64'(4*i));
        end
      end
      e = {64'h8000_0000, 32'h0000_0013};
      tests_run++;
      if (inst_log[ib] !== e) begin tests_failed++; $display("FAIL stream_inst0 got=%h exp=%h", inst_log[ib], e); end
      e = {64'h8000_0004, 32'h0010_0013};
      tests_run++;
      if (inst_log[ib+1] !== e) begin tests_failed++; $display("FAIL stream_inst1 got=%h exp=%h", inst_log[ib+1], e); end
      e = {64'h8000_0008, 32'h0020_0013};
      tests_run++;
      if (inst_log[ib+2] !== e) begin tests_failed++; $display("FAIL stream_inst2 got=%h exp=%h", inst_log[ib+2], e); end
    end
    imem_req_ready = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_backpressure();
    int rb, ib;
    do_reset();
    rb = req_log.size();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    auto_mem       = 1'b1;
    repeat (12) cycle();
    tests_run++;
    if (req_log.size() - rb !== 2) begin tests_failed++; $display("FAIL bp_req_count got=%0d exp=2", req_log.size() - rb); end
    tests_run++;
    if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_valid got=%b exp=0", imem_req_valid); end
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== 32'h0000_0013) begin
      tests_failed++;
      $display("FAIL bp_head got=%b/%h/%h exp=1/%h/00000013", inst_valid, inst_pc, inst, RST_PC);
    end
    ib = inst_log.size();
    inst_ready = 1'b1;
    repeat (6) cycle();
    tests_run++;
    if ((inst_log.size() - ib >= 3) !== 1'b1 || (req_log.size() - rb >= 3) !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_drain_count insts=%0d reqs=%0d", inst_log.size() - ib, req_log.size() - rb);
    end else begin
      tests_run++;
      if (inst_log[ib][XLEN+31:32] !== 64'h8000_0000 || inst_log[ib+1][XLEN+31:32] !== 64'h8000_0004
          || inst_log[ib+2][XLEN+31:32] !== 64'h8000_0008) begin
        tests_failed++;
        $display("FAIL bp_drain_order got=%h,%h,%h exp=80000000,80000004,80000008",
                 inst_log[ib][XLEN+31:32], inst_log[ib+1][XLEN+31:32], inst_log[ib+2][XLEN+31:32]);
      end
      tests_run++;
      if (req_log[rb+2] !== 64'h8000_0008) begin tests_failed++; $display("FAIL bp_resume got=%h exp=80000008", req_log[rb+2]); end
    end
    imem_req_ready = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_redirect_wait();
    int ib;
    do_reset();
    ib = inst_log.size();
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    cycle();                               // accepted, WAIT
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    cycle();                               // DRAIN
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rw_drain got req=%b inst=%b exp=0/0", imem_req_valid, inst_valid);
    end
    cycle();
    cycle();
    man_resp_valid = 1'b1;
    man_resp_data  = 32'hdead_beef;
    cycle();                               // stale response dropped
    man_resp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_stale_inst got=%b exp=0", inst_valid); end
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin
      tests_failed++; $display("FAIL rw_new_req got=%b/%h exp=1/0000000080000100", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    man_resp_valid = 1'b1;
    man_resp_data  = 32'h0010_0093;
    cycle();
    man_resp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 64'h8000_0100 || inst !== 32'h0010_0093) begin
      tests_failed++; $display("FAIL rw_target_inst got=%b/%h/%h exp=1/80000100/00100093", inst_valid, inst_pc, inst);
    end
    tests_run++;
    if (inst_log.size() - ib !== 0) begin tests_failed++; $display("FAIL rw_no_stale got=%0d exp=0", inst_log.size() - ib); end
    cycle();
  endtask

  task automatic test_redirect_resp_same();
    do_reset();
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    cycle();                               // WAIT
    imem_req_ready = 1'b0;
    man_resp_valid = 1'b1;
    man_resp_data  = 32'h1234_5678;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0040;
    cycle();
    man_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rs_buffer got=%b exp=0", inst_valid); end
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0040) begin
      tests_failed++; $display("FAIL rs_req got=%b/%h exp=1/0000000080000040", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_fault();
    int rb;
    do_reset();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    cycle();                               // HALT
    redirect_valid = 1'b0;
    tests_run++;
    if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flt_set got=%b/%b/%b exp=1/0/0", fetch_fault, imem_req_valid, inst_valid);
    end
    rb = req_log.size();
    imem_req_ready = 1'b1;
    repeat (4) cycle();
    tests_run++;
    if (req_log.size() - rb !== 0 || fetch_fault !== 1'b1) begin
      tests_failed++; $display("FAIL flt_hold got reqs=%0d fault=%b exp=0/1", req_log.size() - rb, fetch_fault);
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
      tests_failed++; $display("FAIL flt_clear got=%b/%b/%h exp=0/1/0000000080000200", fetch_fault, imem_req_valid, imem_req_addr);
    end
    // misaligned redirect with a request in flight: DRAIN then HALT
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0301;
    cycle();
    redirect_valid = 1'b0;
    man_resp_valid = 1'b1;
    man_resp_data  = 32'h0000_0013;
    cycle();
    man_resp_valid = 1'b0;
    cycle();
    tests_run++;
    if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flt_drain_halt got=%b/%b/%b exp=1/0/0", fetch_fault, imem_req_valid, inst_valid);
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    cycle();                               // WAIT
    imem_req_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    man_resp_valid = 1'b1;
    man_resp_data  = 32'h0bad_0bad;
    cycle();
    man_resp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_inst got=%b exp=0", inst_valid); end
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      tests_failed++; $display("FAIL rst_wait_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffffffffffc", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    cycle();
    imem_req_ready = 1'b0;
    man_resp_valid = 1'b1;
    man_resp_data  = 32'h0000_0013;
    cycle();
    man_resp_valid = 1'b0;
    tests_run++;
    if (inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_req_addr !== 64'h0) begin
      tests_failed++; $display("FAIL wrap_pc got inst_pc=%h addr=%h exp=fffffffffffffffc/0", inst_pc, imem_req_addr);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp_same();
    test_fault();
    test_reset_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
